// File: rtl/posit_accum_scheduler_pkg.sv
// Shared types for the posit accumulation scheduler: FSM state encoding and
// the denormalized operand word forwarded to the accumulator.
package posit_defines;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    STREAM = 2'd2
  } sched_state_t;

  // Field widths sized for an 8-bit posit: scale covers the regime plus
  // exponent range, fraction holds the bits below the hidden one.
  localparam int PD_SCALE_W = 6;
  localparam int PD_FRAC_W  = 5;

  typedef struct packed {
    logic                         sign;
    logic                         zero;
    logic                         nar;
    logic signed [PD_SCALE_W-1:0] scale;
    logic [PD_FRAC_W-1:0]         frac;
    logic                         guard;
    logic                         round;
    logic                         sticky;
  } pd_word_t;

  localparam int PD_W = $bits(pd_word_t);

endpackage

// File: rtl/posit_accum_scheduler_tag_fifo.sv
// Tag FIFO: remembers which requester owns each window in flight so the
// final sum can be labelled. Push when full and pop when empty are ignored.
module posit_sched_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents are don't-care while the entry is not valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/posit_accum_scheduler.sv
// Posit accumulation scheduler: round-robin grants whole operand windows from
// N_REQ requesters to one accumulator and labels each final sum with the
// owning requester id. Optional protocol checking: POSIT_SCHED_ERR_CHECK_EN.
//
// Handshake: every stream uses rts (valid) / rtr (ready). A beat transfers on
// a rising edge where both are high; a sender holds rts and payload stable
// until then, and rtr may depend combinationally on rts.
module posit_accum_scheduler
  import posit_defines::*;
#(
  parameter int N_REQ       = 4,
  parameter int POSIT_WIDTH = 8,
  parameter int POSIT_ES    = 0,
  parameter int TAG_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_rts_i,
  input  logic [N_REQ-1:0]           req_sow_i,
  input  logic [N_REQ-1:0]           req_eow_i,
  input  logic [N_REQ*PD_W-1:0]      req_data_i,
  output logic [N_REQ-1:0]           req_rtr_o,
  output logic                       acc_rts_o,
  output logic                       acc_sow_o,
  output logic                       acc_eow_o,
  output logic [PD_W-1:0]            acc_data_o,
  input  logic                       acc_rtr_i,
  input  logic                       res_rts_i,
  input  logic                       res_eow_i,
  input  logic [POSIT_WIDTH-1:0]     res_data_i,
  output logic                       res_rtr_o,
  output logic                       out_rts_o,
  output logic [POSIT_WIDTH-1:0]     out_data_o,
  output logic [$clog2(N_REQ)-1:0]   out_id_o,
  input  logic                       out_rtr_i,
  output logic                       err_o,
  output sched_state_t               dbg_state_o,
  output logic [$clog2(N_REQ)-1:0]   dbg_rr_ptr_o
);

  localparam int ID_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || POSIT_ES < 0 || POSIT_ES > POSIT_WIDTH - 3) begin : g_bad_cfg
    $error("posit_accum_scheduler: unsupported parameter combination");
  end

  sched_state_t    state_q, state_d;
  logic [ID_W-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] arb_id;
  logic            arb_found;
  logic            beat_xfer;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ID_W-1:0] fifo_head;
  int              idx;

  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

  // Round-robin search for a requester opening a window, starting at rr_ptr.
  always_comb begin
    arb_found = 1'b0;
    arb_id    = '0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!arb_found && req_rts_i[idx] && req_sow_i[idx]) begin
        arb_found = 1'b1;
        arb_id    = ID_W'(idx);
      end
    end
  end

  // Combinational forwarding of the granted requester while streaming.
  always_comb begin
    acc_rts_o  = 1'b0;
    acc_sow_o  = 1'b0;
    acc_eow_o  = 1'b0;
    acc_data_o = '0;
    req_rtr_o  = '0;
    if (state_q == STREAM) begin
      acc_rts_o         = req_rts_i[gnt_q];
      acc_sow_o         = req_sow_i[gnt_q];
      acc_eow_o         = req_eow_i[gnt_q];
      acc_data_o        = req_data_i[gnt_q*PD_W +: PD_W];
      req_rtr_o[gnt_q]  = acc_rtr_i;
    end
  end

  assign beat_xfer = acc_rts_o & acc_rtr_i;

  // Next-state logic: one arbitration cycle, then stream until eow transfers.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    fifo_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_found && !fifo_full) begin
          gnt_d   = arb_id;
          state_d = GRANT;
        end
      end
      GRANT: begin
        fifo_push = 1'b1;
        state_d   = STREAM;
      end
      STREAM: begin
        if (beat_xfer && acc_eow_o) begin
          state_d  = IDLE;
          rr_ptr_d = (gnt_q == ID_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, grant and round-robin registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Result path: partial sums are swallowed, final sums leave with their tag.
  always_comb begin
    out_rts_o  = res_rts_i & res_eow_i;
    res_rtr_o  = res_eow_i ? out_rtr_i : 1'b1;
    out_data_o = out_rts_o ? res_data_i : '0;
    out_id_o   = out_rts_o ? fifo_head : '0;
    fifo_pop   = out_rts_o & out_rtr_i & ~fifo_empty;
  end

  posit_sched_tag_fifo #(
    .W     (ID_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (gnt_q),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef POSIT_SCHED_ERR_CHECK_EN
  logic first_q;
  logic err_q;

  // Sticky error: sow after the first beat of a window, or a final sum with no tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == GRANT) first_q <= 1'b1;
      else if (beat_xfer)   first_q <= 1'b0;
      if ((beat_xfer && acc_sow_o && !first_q) || (out_rts_o && fifo_empty))
        err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_posit_accum_scheduler.sv
// Bench for posit_accum_scheduler: directed scenarios plus randomized windows,
// checked against a window-level round-robin model and a result scoreboard.
module tb_posit_accum_scheduler;
  import posit_defines::*;

  localparam int N    = 4;
  localparam int PW   = 8;
  localparam int ID_W = 2;
`ifdef POSIT_SCHED_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct packed {
    logic            sow;
    logic            eow;
    logic [PD_W-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            sow;
    logic            eow;
    logic [PD_W-1:0] data;
  } acc_exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      req_rts = '0, req_sow = '0, req_eow = '0;
  logic [N*PD_W-1:0] req_data = '0;
  logic [N-1:0]      req_rtr_o;
  logic              acc_rts_o, acc_sow_o, acc_eow_o;
  logic [PD_W-1:0]   acc_data_o;
  logic              acc_rtr_i = 1'b1;
  logic              res_rts_i = 1'b0, res_eow_i = 1'b0;
  logic [PW-1:0]     res_data_i = '0;
  logic              res_rtr_o, out_rts_o;
  logic [PW-1:0]     out_data_o;
  logic [ID_W-1:0]   out_id_o;
  logic              out_rtr_i = 1'b1;
  logic              err_o;
  sched_state_t      dbg_state_o;
  logic [ID_W-1:0]   dbg_rr_ptr_o;

  posit_accum_scheduler #(.N_REQ(N), .POSIT_WIDTH(PW), .POSIT_ES(0), .TAG_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_rts_i(req_rts), .req_sow_i(req_sow), .req_eow_i(req_eow), .req_data_i(req_data),
    .req_rtr_o(req_rtr_o),
    .acc_rts_o(acc_rts_o), .acc_sow_o(acc_sow_o), .acc_eow_o(acc_eow_o),
    .acc_data_o(acc_data_o), .acc_rtr_i(acc_rtr_i),
    .res_rts_i(res_rts_i), .res_eow_i(res_eow_i), .res_data_i(res_data_i), .res_rtr_o(res_rtr_o),
    .out_rts_o(out_rts_o), .out_data_o(out_data_o), .out_id_o(out_id_o), .out_rtr_i(out_rtr_i),
    .err_o(err_o), .dbg_state_o(dbg_state_o), .dbg_rr_ptr_o(dbg_rr_ptr_o)
  );

  // model and scoreboard state
  beat_t                 rq [N][$];       // beats still to be offered by each requester
  beat_t                 wq [N][$];       // windows not yet placed in the expected order
  acc_exp_t              exp_acc_q[$];    // expected accumulator-side beats in order
  logic [PW-1:0]         res_pend_q[$];   // final sums the accumulator model still owes
  logic [ID_W+PW-1:0]    exp_q[$];        // expected {id, sum} on the output stream
  int                    model_rr = 0;
  int                    n_checks = 0, n_pass = 0;
  int                    acc_beats = 0, out_count = 0;
  logic                  rand_mode = 1'b0, out_block = 1'b0;
  sched_state_t          last_state;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic update_drives();
    for (int k = 0; k < N; k++) begin
      if (rq[k].size() > 0) begin
        req_rts[k] = 1'b1;
        req_sow[k] = rq[k][0].sow;
        req_eow[k] = rq[k][0].eow;
        req_data[k*PD_W +: PD_W] = rq[k][0].data;
      end else begin
        req_rts[k] = 1'b0;
        req_sow[k] = 1'b0;
        req_eow[k] = 1'b0;
        req_data[k*PD_W +: PD_W] = '0;
      end
    end
  endtask

  task automatic push_window(input int k, input int len, input int resow);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.sow  = (i == 0) || (i == resow);
      b.eow  = (i == len - 1);
      b.data = PD_W'($urandom);
      rq[k].push_back(b);
      wq[k].push_back(b);
    end
  endtask

  // Window-level reference: pick the first requester at or after the pointer
  // that still has a window, emit that whole window, advance past it.
  task automatic plan();
    int    k;
    bit    found;
    beat_t b;
    acc_exp_t e;
    while (1) begin
      found = 0;
      k = 0;
      for (int i = 0; i < N && !found; i++) begin
        k = (model_rr + i) % N;
        if (wq[k].size() > 0) found = 1;
      end
      if (!found) break;
      do begin
        b = wq[k].pop_front();
        e.id = ID_W'(k); e.sow = b.sow; e.eow = b.eow; e.data = b.data;
        exp_acc_q.push_back(e);
      end while (!b.eow);
      model_rr = (k + 1) % N;
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin
      rq[k].delete();
      wq[k].delete();
    end
    exp_acc_q.delete();
    res_pend_q.delete();
    exp_q.delete();
    model_rr = 0;
    acc_beats = 0;
    out_count = 0;
  endtask

  // One clock: sample and score at negedge, then drive new inputs after posedge.
  task automatic cycle();
    logic [N-1:0]       pop_mask;
    logic               res_done;
    acc_exp_t           e;
    logic [ID_W+PW-1:0] x;
    int                 r;
    @(negedge clk);
    last_state = dbg_state_o;
    pop_mask = req_rts & req_rtr_o;
    res_done = 1'b0;
    if (acc_rts_o && acc_rtr_i) begin
      check("acc_beat_expected", 32'(exp_acc_q.size() != 0), 32'd1);
      if (exp_acc_q.size() != 0) begin
        e = exp_acc_q.pop_front();
        check("acc_data", 32'(acc_data_o), 32'(e.data));
        check("acc_sow", 32'(acc_sow_o), 32'(e.sow));
        check("acc_eow", 32'(acc_eow_o), 32'(e.eow));
        check("req_rtr_sel", 32'(req_rtr_o), 32'd1 << e.id);
        acc_beats++;
        if (e.eow) begin
          r = $urandom;
          res_pend_q.push_back(PW'(r));
          exp_q.push_back({e.id, PW'(r)});
        end
      end
    end
    if (res_rts_i) begin
      if (res_eow_i) begin
        check("out_rts", 32'(out_rts_o), 32'd1);
        check("res_rtr_eow", 32'(res_rtr_o), 32'(out_rtr_i));
        if (out_rtr_i) begin
          check("out_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            check("out_id", 32'(out_id_o), 32'(x[PW +: ID_W]));
            check("out_data", 32'(out_data_o), 32'(x[PW-1:0]));
            out_count++;
          end
          res_done = 1'b1;
        end
      end else begin
        check("res_drop_rtr", 32'(res_rtr_o), 32'd1);
        check("res_drop_out", 32'(out_rts_o), 32'd0);
        res_done = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (pop_mask[k] && rq[k].size() > 0) void'(rq[k].pop_front());
    if (res_done) res_rts_i = 1'b0;
    if (!res_rts_i) begin
      r = $urandom_range(0, 3);
      if (r != 0 && res_pend_q.size() != 0) begin
        res_rts_i = 1'b1; res_eow_i = 1'b1; res_data_i = res_pend_q.pop_front();
      end else if (r == 0) begin
        res_rts_i = 1'b1; res_eow_i = 1'b0; res_data_i = PW'($urandom);
      end else begin
        res_eow_i = 1'b0; res_data_i = '0;
      end
    end
    acc_rtr_i = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    out_rtr_i = out_block ? 1'b0 : (rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
    update_drives();
  endtask

  function automatic bit drained();
    bit d = (exp_acc_q.size() == 0) && (res_pend_q.size() == 0) && (exp_q.size() == 0);
    for (int k = 0; k < N; k++) if (rq[k].size() != 0) d = 0;
    return d;
  endfunction

  task automatic run_drain(input int budget);
    int c = 0;
    while (!drained() && c < budget) begin
      cycle();
      c++;
    end
    check("drain_in_budget", 32'(drained()), 32'd1);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_rtr", 32'(req_rtr_o), 32'd0);
    check("rst_acc_rts", 32'(acc_rts_o), 32'd0);
    check("rst_acc_sow", 32'(acc_sow_o), 32'd0);
    check("rst_acc_eow", 32'(acc_eow_o), 32'd0);
    check("rst_acc_data", 32'(acc_data_o), 32'd0);
    check("rst_out_rts", 32'(out_rts_o), 32'd0);
    check("rst_out_data", 32'(out_data_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_state", 32'(dbg_state_o), 32'(IDLE));
    check("rst_rr_ptr", 32'(dbg_rr_ptr_o), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    res_rts_i = 1'b0; res_eow_i = 1'b0; res_data_i = '0;
    acc_rtr_i = 1'b1; out_rtr_i = 1'b1; out_block = 1'b0;
    update_drives();
    @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    do_reset();

    // 3-beat window on requester 2: one arbitration cycle, tag 2, pointer to 3
    push_window(2, 3, -1);
    plan();
    update_drives();
    cycle(); check("t1_idle_sees_sow", 32'(last_state), 32'(IDLE));
    cycle(); check("t1_grant", 32'(last_state), 32'(GRANT));
    cycle(); check("t1_stream", 32'(last_state), 32'(STREAM));
    run_drain(60);
    check("t1_beats", 32'(acc_beats), 32'd3);
    check("t1_outs", 32'(out_count), 32'd1);
    check("t1_rr_ptr", 32'(dbg_rr_ptr_o), 32'd3);

    // all four open windows together, twice each: fair rotation
    do_reset();
    for (int rep = 0; rep < 2; rep++)
      for (int k = 0; k < N; k++) push_window(k, $urandom_range(1, 3), -1);
    plan();
    update_drives();
    run_drain(200);
    check("t2_outs", 32'(out_count), 32'd8);

    // four windows in flight with the output blocked: fifth waits for a pop
    do_reset();
    out_block = 1'b1;
    for (int k = 0; k < N; k++) push_window(k, 1, -1);
    push_window(0, 1, -1);
    plan();
    update_drives();
    repeat (30) cycle();
    check("t3_fifth_held_beats", 32'(acc_beats), 32'd4);
    check("t3_fifth_held_rtr", 32'(req_rtr_o), 32'd0);
    check("t3_fifth_held_state", 32'(last_state), 32'(IDLE));
    out_rtr_i = 1'b1;
    cycle();
    check("t3_one_pop", 32'(out_count), 32'd1);
    cycle(); check("t3_idle_after_pop", 32'(last_state), 32'(IDLE));
    cycle(); check("t3_fifth_grant", 32'(last_state), 32'(GRANT));
    out_block = 1'b0;
    run_drain(100);
    check("t3_outs", 32'(out_count), 32'd5);

    // single-beat window on requester 1, then requester 0
    do_reset();
    push_window(1, 1, -1);
    plan();
    update_drives();
    cycle();
    push_window(0, 1, -1);
    plan();
    update_drives();
    run_drain(60);
    check("t4_outs", 32'(out_count), 32'd2);

    // reset mid-window: leftover beats without sow are ignored, new tag clean
    do_reset();
    push_window(3, 4, -1);
    plan();
    update_drives();
    repeat (3) cycle();
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) wq[k].delete();
    exp_acc_q.delete(); res_pend_q.delete(); exp_q.delete();
    model_rr = 0; acc_beats = 0; out_count = 0;
    res_rts_i = 1'b0; res_eow_i = 1'b0; res_data_i = '0;
    update_drives();
    @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (5) cycle();
    check("t5_no_sow_ignored_state", 32'(last_state), 32'(IDLE));
    check("t5_no_sow_ignored_beats", 32'(rq[3].size()), 32'd3);
    rq[3].delete();
    push_window(1, 2, -1);
    plan();
    update_drives();
    run_drain(60);
    check("t5_outs", 32'(out_count), 32'd1);

    // sow re-asserted on beat 2 of a granted window
    do_reset();
    push_window(0, 4, 1);
    plan();
    update_drives();
    run_drain(60);
    check("t6_err_set", 32'(err_o), 32'(EXP_ERR));
    repeat (5) cycle();
    check("t6_err_sticky", 32'(err_o), 32'(EXP_ERR));
    do_reset();

    // randomized windows, random back-pressure on both sides
    rand_mode = 1'b1;
    for (int round = 0; round < 8; round++) begin
      for (int k = 0; k < N; k++) begin
        int nw = $urandom_range(0, 2);
        for (int w = 0; w < nw; w++) push_window(k, $urandom_range(1, 4), -1);
      end
      plan();
      update_drives();
      run_drain(600);
      check("rand_rr_ptr", 32'(dbg_rr_ptr_o), 32'(model_rr));
    end
    check("final_err", 32'(err_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/posit_accum_scheduler.md
POSIT_ACCUM_SCHEDULER -- requirements
Module: posit_accum_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requester streams (2..16).
REQ-002 SHALL have parameter POSIT_WIDTH, default 8: posit word width.
REQ-003 SHALL have parameter POSIT_ES, default 0: exponent field width.
REQ-004 SHALL have parameter TAG_DEPTH, default 4: maximum windows in flight (power of 2).
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port req_rts_i, input, N_REQ: per-requester ready-to-send.
REQ-008 SHALL have port req_sow_i, input, N_REQ: per-requester start-of-window.
REQ-009 SHALL have port req_eow_i, input, N_REQ: per-requester end-of-window.
REQ-010 SHALL have port req_data_i, input, N_REQ*PD_W: packed denormalized operands, requester k at slice k; PD_W = width of pd_word_t.
REQ-011 SHALL have port req_rtr_o, output, N_REQ: per-requester ready-to-receive.
REQ-012 SHALL have ports acc_rts_o, acc_sow_o, acc_eow_o (output, 1), acc_data_o (output, PD_W) and acc_rtr_i (input, 1): operand stream to the accumulator.
REQ-013 SHALL have ports res_rts_i, res_eow_i (input, 1), res_data_i (input, POSIT_WIDTH) and res_rtr_o (output, 1): running-sum stream from the accumulator.
REQ-014 SHALL have ports out_rts_o (output, 1), out_data_o (output, POSIT_WIDTH), out_id_o (output, $clog2(N_REQ)) and out_rtr_i (input, 1): final sums tagged with requester id.
REQ-015 SHALL have port err_o, output, 1: sticky protocol-error flag.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT, STREAM.
REQ-017 IDLE: SHALL hold req_rtr_o at 0; when some k has req_rts_i[k] & req_sow_i[k] and the tag FIFO is not full, SHALL register grant id (round-robin from pointer rr_ptr) and go to GRANT.
REQ-018 GRANT: SHALL push grant id into the tag FIFO and go to STREAM; the arbitration cost is exactly one cycle.
REQ-019 STREAM: SHALL forward the granted requester combinationally: acc_rts_o = req_rts_i[g], acc_data/sow/eow = slice g, req_rtr_o[g] = acc_rtr_i; all other req_rtr_o bits SHALL be 0.
REQ-020 A beat transfers when acc_rts_o & acc_rtr_i; on a transferred beat with eow, SHALL go to IDLE and set rr_ptr = (g+1) mod N_REQ.
REQ-021 A single-beat window (sow and eow on the same beat) SHALL complete STREAM in one transfer.
REQ-022 Requesters presenting data without sow in IDLE SHALL be ignored (not granted, not consumed).
REQ-023 Non-eow results SHALL be consumed and dropped: res_rtr_o = 1 when res_eow_i = 0.
REQ-024 For an eow result: out_rts_o = res_rts_i; res_rtr_o = out_rtr_i; out_data_o = res_data_i; out_id_o = tag FIFO head. SHALL pop the FIFO on transfer.
REQ-025 A FIFO push (GRANT) and pop (eow result) in the same cycle SHALL both take effect, with occupancy unchanged.
REQ-026 When the FIFO is full, IDLE SHALL not grant until a pop frees an entry.

Reset
REQ-027 On rst_n = 0 at a clock edge: state = IDLE, rr_ptr = 0, FIFO empty, err_o = 0, and all req_rtr_o, acc_rts_o, acc_sow_o, acc_eow_o and out_rts_o = 0. acc_data_o and out_data_o SHALL be 0.
REQ-028 Reset mid-window SHALL abandon the window and its tag; no partial result is tagged afterwards.

Configuration
REQ-029 Macro POSIT_SCHED_ERR_CHECK_EN SHALL control error checking.
REQ-029a Defined: err_o SHALL set and hold until reset when any of these occurs:
- the granted requester asserts sow on a STREAM beat other than the first;
- an eow result arrives with the FIFO empty.
REQ-029b Undefined: err_o SHALL be tied to 0 and no checking logic is built.

Structure
REQ-030 Package posit_defines SHALL hold sched_state_t (IDLE/GRANT/STREAM) and pd_word_t (packed sign, zero, NaR, scale, fraction, guard, round, sticky).
REQ-031 The tag FIFO SHALL be sub-module posit_sched_tag_fifo (width $clog2(N_REQ), depth TAG_DEPTH, full/empty flags).

Verification
REQ-032 Requester 2 sends a 3-beat window, accumulator always ready -> GRANT one cycle after sow is seen; 3 beats forwarded; out_id_o = 2 on the eow result; rr_ptr = 3.
REQ-033 All 4 requesters assert sow simultaneously, repeated windows -> grants in order 0,1,2,3,0 with no requester starved.
REQ-034 TAG_DEPTH = 4 windows in flight, out_rtr_i = 0 -> the fifth sow is not granted; a single out_rtr_i pulse pops one tag and the fifth grant occurs next IDLE cycle.
REQ-035 Single-beat window (sow = eow = 1) on requester 1, immediately followed by requester 0 -> both complete; outputs are id 1 then id 0.
REQ-036 rst_n low for one cycle mid-STREAM -> all outputs 0 next cycle; FIFO empty; a new window is tagged correctly.
REQ-037 With POSIT_SCHED_ERR_CHECK_EN, the granted requester re-asserts sow on beat 2 -> err_o = 1 and stays 1 until reset.
